// File: rtl/lfsr_rand_gen.sv
// Galois-LFSR random source with seed load, lockup recovery and range-limited draws.
// Optional entropy mixing into the MSB on every step: define RNG_ENTROPY_MIX_EN.
module lfsr_rand_gen #(
  parameter int unsigned     WIDTH          = 16,
  parameter logic [WIDTH-1:0] TAPS          = 16'hB400,
  parameter logic [WIDTH-1:0] SEED          = 16'hACE1,
  parameter int unsigned     STEPS_PER_DRAW = 1,
  parameter int unsigned     MAX_TRIES      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] range_i,
  output logic             rnd_valid_o,
  input  logic             rnd_ready_i,
  output logic [WIDTH-1:0] rnd_num_o,
  input  logic             entropy_i
);

  localparam int unsigned SCW = (STEPS_PER_DRAW > 1) ? $clog2(STEPS_PER_DRAW) : 1;
  localparam logic [SCW-1:0] LAST_STEP = SCW'(STEPS_PER_DRAW - 1);
  localparam logic [4:0]     TRY_LIMIT = 5'(MAX_TRIES);

  typedef enum logic [1:0] {IDLE, STEP, CHECK, VALID} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [3:0]       tries_q, tries_d;
  logic [SCW-1:0]   steps_q, steps_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] step_n;
  logic [WIDTH-1:0] cand;

  // Smear the MSB of (r-1) downward: gives 2^ceil(log2(r)) - 1.
  function automatic logic [WIDTH-1:0] range_mask(input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] m;
    m = r - 1'b1;
    for (int unsigned i = 1; i < WIDTH; i = i * 2) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

`ifdef RNG_ENTROPY_MIX_EN
`else
  logic unused_entropy;
  assign unused_entropy = entropy_i;
`endif

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    range_d = range_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    steps_d = steps_q;
    num_d   = num_q;
    valid_d = valid_q;
    step_n  = '0;
    cand    = lfsr_q & mask_q;

    if (seed_load_i) begin
      lfsr_d  = (seed_i == '0) ? SEED : seed_i;
      state_d = IDLE;
      valid_d = 1'b0;
      tries_d = '0;
      steps_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            range_d = range_i;
            mask_d  = range_mask(range_i);
            tries_d = '0;
            steps_d = '0;
            state_d = STEP;
          end
        end
        STEP: begin
          step_n = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
`ifdef RNG_ENTROPY_MIX_EN
          step_n[WIDTH-1] = step_n[WIDTH-1] ^ entropy_i;
`endif
          lfsr_d = (step_n == '0) ? SEED : step_n;
          if (steps_q == LAST_STEP) begin
            steps_d = '0;
            state_d = CHECK;
          end else begin
            steps_d = steps_q + 1'b1;
          end
        end
        CHECK: begin
          state_d = VALID;
          valid_d = 1'b1;
          if (range_q == '0) begin
            num_d = lfsr_q;
          end else if (range_q == WIDTH'(1)) begin
            num_d = '0;
          end else if (cand < range_q) begin
            num_d = cand;
          end else if (({1'b0, tries_q} + 5'd1) < TRY_LIMIT) begin
            tries_d = tries_q + 1'b1;
            state_d = STEP;
            valid_d = 1'b0;
          end else begin
            // cand <= mask < 2*range, so the folded value is always in range
            num_d = cand - range_q;
          end
        end
        VALID: begin
          if (rnd_ready_i) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      range_q <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      steps_q <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      range_q <= range_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      steps_q <= steps_d;
      num_q   <= num_d;
      valid_q <= valid_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rnd_valid_o = valid_q;
  assign rnd_num_o   = num_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Bench for lfsr_rand_gen: transaction-level reference model plus directed literal draws.
module tb_lfsr_rand_gen;

  localparam int unsigned W = 8;
  localparam logic [7:0]  TAPS = 8'hB8;
  localparam logic [7:0]  SEED = 8'h01;
  localparam int          S    = 1;
  localparam int          MT   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       seed_load;
  logic [7:0] seed;
  logic       req_valid;
  logic       req_ready_o;
  logic [7:0] range_v;
  logic       rnd_valid_o;
  logic       rnd_ready;
  logic [7:0] rnd_num_o;
  logic       entropy;

  int checks = 0;
  int errors = 0;

  lfsr_rand_gen #(
    .WIDTH(W), .TAPS(TAPS), .SEED(SEED), .STEPS_PER_DRAW(S), .MAX_TRIES(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .seed_load_i(seed_load), .seed_i(seed),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .range_i(range_v),
    .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready), .rnd_num_o(rnd_num_o),
    .entropy_i(entropy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mstep(input logic [7:0] s);
    int v;
    v = int'(s) / 2;
    if (int'(s) % 2 == 1) v = v ^ int'(TAPS);
    if (v == 0) v = int'(SEED);
    return 8'(v);
  endfunction

  // Reference model: whole draw resolved at accept time, then a countdown to valid.
  logic [7:0] m_lfsr = SEED;
  logic       m_valid = 1'b0;
  logic [7:0] m_num = 8'h00;
  logic [7:0] m_res = 8'h00;
  int         m_busy = 0;

  always @(posedge clk) begin : model
    int k, t, lat;
    logic [7:0] mask, cand;
    if (rst) begin
      m_lfsr = SEED; m_valid = 1'b0; m_num = 8'h00; m_busy = 0;
    end else if (seed_load) begin
      m_lfsr = (seed == 8'h00) ? SEED : seed;
      m_valid = 1'b0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid = 1'b1;
        m_num = m_res;
      end
    end else if (m_valid) begin
      if (rnd_ready) m_valid = 1'b0;
    end else if (req_valid) begin
      k = 0;
      while ((1 << k) < int'(range_v)) k++;
      mask = 8'((1 << k) - 1);
      t = 0;
      forever begin
        for (int i = 0; i < S; i++) m_lfsr = mstep(m_lfsr);
        if (range_v == 8'd0) begin m_res = m_lfsr; break; end
        if (range_v == 8'd1) begin m_res = 8'd0; break; end
        cand = m_lfsr & mask;
        if (cand < range_v) begin m_res = cand; break; end
        if (t + 1 >= MT) begin m_res = cand - range_v; break; end
        t++;
      end
      lat = S + 2 + t * (S + 1);
      m_busy = lat - 1;
    end
    #1;
    chk("cyc_valid", {31'd0, rnd_valid_o}, {31'd0, m_valid});
    chk("cyc_num", {24'd0, rnd_num_o}, {24'd0, m_num});
    chk("cyc_ready", {31'd0, req_ready_o}, {31'd0, (m_busy == 0 && !m_valid)});
  end

  // Called at a negedge, returns at a negedge.
  task automatic draw(input logic [7:0] rng, input logic [7:0] exp, input int exp_edges,
                      input int hold, input bit release_it);
    int n;
    logic [7:0] held;
    chk("draw_ready", {31'd0, req_ready_o}, 32'd1);
    req_valid = 1'b1; range_v = rng; rnd_ready = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    req_valid = 1'b0;
    range_v = 8'($urandom);
    while (!rnd_valid_o && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("draw_latency", n, exp_edges);
    chk("draw_num", {24'd0, rnd_num_o}, {24'd0, exp});
    held = rnd_num_o;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      @(negedge clk);
      chk("hold_num", {24'd0, rnd_num_o}, {24'd0, held});
      chk("hold_valid", {31'd0, rnd_valid_o}, 32'd1);
      chk("hold_ready", {31'd0, req_ready_o}, 32'd0);
    end
    req_valid = 1'b0;
    if (release_it) begin
      rnd_ready = 1'b1;
      @(negedge clk);
      rnd_ready = 1'b0;
      chk("release_valid", {31'd0, rnd_valid_o}, 32'd0);
      chk("release_ready", {31'd0, req_ready_o}, 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("rst_num", {24'd0, rnd_num_o}, 32'd0);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1; seed_load = 1'b0; seed = 8'h00; req_valid = 1'b0;
    range_v = 8'h00; rnd_ready = 1'b0; entropy = 1'b0;
    chk("pin_step_01", {24'd0, mstep(8'h01)}, 32'hB8);
    chk("pin_step_B8", {24'd0, mstep(8'hB8)}, 32'h5C);
    @(negedge clk);
    @(negedge clk);
    do_reset();

    draw(8'd0, 8'hB8, 3, 0, 1);
    draw(8'd0, 8'h5C, 3, 0, 1);
    draw(8'd0, 8'h2E, 3, 0, 1);
    draw(8'd0, 8'h17, 3, 0, 1);

    do_reset();
    draw(8'd100, 8'd56, 3, 0, 1);
    do_reset();
    draw(8'd40, 8'd28, 5, 0, 1);

    seed_load = 1'b1; seed = 8'h00; req_valid = 1'b1; range_v = 8'd0;
    @(negedge clk);
    seed_load = 1'b0; req_valid = 1'b0;
    chk("sl_ready", {31'd0, req_ready_o}, 32'd1);
    draw(8'd0, 8'hB8, 3, 0, 1);

    draw(8'd0, 8'h5C, 3, 10, 1);
    draw(8'd0, 8'h2E, 3, 0, 1);

    req_valid = 1'b1; range_v = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midstep_busy", {31'd0, req_ready_o}, 32'd0);
    do_reset();
    draw(8'd0, 8'hB8, 3, 2, 0);

    seed_load = 1'b1; seed = 8'h5C;
    @(negedge clk);
    seed_load = 1'b0;
    chk("slv_valid", {31'd0, rnd_valid_o}, 32'd0);
    chk("slv_ready", {31'd0, req_ready_o}, 32'd1);
    draw(8'd0, 8'h2E, 3, 0, 1);

    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      seed_load = ($urandom_range(0, 59) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      req_valid = 1'($urandom);
      case ($urandom_range(0, 5))
        0: r = 8'd0;
        1: r = 8'd1;
        2: r = 8'(1 << $urandom_range(0, 7));
        3: r = 8'((1 << $urandom_range(1, 6)) + 1);
        default: r = 8'($urandom);
      endcase
      range_v = r;
      rnd_ready = ($urandom_range(0, 2) != 0);
      entropy = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; seed_load = 1'b0; req_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
